// File: rtl/ann_layer_sequencer_pkg.sv
// Shared types and helpers for the ANN layer sequencer.
package ann_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ_IMAGE,
    S_WAIT_IMAGE,
    S_LOAD_IMAGE,
    S_REQ_COEF,
    S_WAIT_COEF,
    S_PAUSE_COEF,
    S_START_LAYER,
    S_WAIT_LAYER,
    S_ADVANCE,
    S_DONE,
    S_ERROR
  } ann_seq_state_t;

  // Width of layer/select/load fields: indices 0..n plus the image load code n+1.
  function automatic int ann_lw(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/ann_layer_sequencer_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, flags the last allowed cycle.
module ann_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // TIMEOUT of zero disables the watchdog entirely.
  always_comb begin
    expired = (TIMEOUT != 0) && en && (count == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/ann_layer_sequencer.sv
// N-layer ANN sequencer: image fetch, then per-layer coefficient fetch, node run and output load.
module ann_layer_sequencer
  import ann_pkg::*;
#(
  parameter int unsigned                   NUM_LAYERS   = 3,
  parameter int unsigned                   CNT_W        = 7,
  parameter logic [NUM_LAYERS*CNT_W-1:0]   LAYER_INPUTS = {7'd8, 7'd16, 7'd64},
  parameter int unsigned                   TIMEOUT      = 1024
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start_detecting,
  input  logic [ann_lw(NUM_LAYERS)-1:0] layers_used,
  input  logic                          abort,
  input  logic                          image_weights_loaded,
  input  logic                          n_start_done,
  output logic [CNT_W-1:0]              max_input,
  output logic                          coeff_ready,
  output logic                          reset_accum,
  output logic [ann_lw(NUM_LAYERS)-1:0] load_next,
  output logic                          request_coef,
  output logic [ann_lw(NUM_LAYERS)-1:0] coef_select,
  output logic [ann_lw(NUM_LAYERS)-1:0] cur_layer,
  output logic                          busy,
  output logic                          done_processing,
  output logic                          error
);

  localparam int unsigned LW = ann_lw(NUM_LAYERS);

  ann_seq_state_t state, state_n;
  logic [LW-1:0]  cur_layer_n, layers_lat, layers_lat_n, coef_sel_n;
  logic           wd_clear, wd_en, wd_expired;
  int unsigned    slice_idx;

  ann_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      cur_layer   <= '0;
      layers_lat  <= LW'(NUM_LAYERS);
      coef_select <= LW'(NUM_LAYERS);
    end else begin
      state       <= state_n;
      cur_layer   <= cur_layer_n;
      layers_lat  <= layers_lat_n;
      coef_select <= coef_sel_n;
    end
  end

  always_comb begin
    state_n      = state;
    cur_layer_n  = cur_layer;
    layers_lat_n = layers_lat;
    coef_sel_n   = coef_select;

    case (state)
      S_IDLE: begin
        if (start_detecting) begin
          state_n      = S_REQ_IMAGE;
          layers_lat_n = (layers_used == '0 || layers_used > LW'(NUM_LAYERS))
                         ? LW'(NUM_LAYERS) : layers_used;
        end
      end
      S_REQ_IMAGE:   state_n = S_WAIT_IMAGE;
      S_WAIT_IMAGE: begin
        if (image_weights_loaded) state_n = S_LOAD_IMAGE;
        else if (wd_expired)      state_n = S_ERROR;
      end
      S_LOAD_IMAGE:  state_n = S_REQ_COEF;
      S_REQ_COEF:    state_n = S_WAIT_COEF;
      S_WAIT_COEF: begin
        if (image_weights_loaded) state_n = S_PAUSE_COEF;
        else if (wd_expired)      state_n = S_ERROR;
      end
      S_PAUSE_COEF:  state_n = S_START_LAYER;
      S_START_LAYER: state_n = S_WAIT_LAYER;
      S_WAIT_LAYER: begin
        if (n_start_done)    state_n = S_ADVANCE;
        else if (wd_expired) state_n = S_ERROR;
      end
      S_ADVANCE: begin
        cur_layer_n = cur_layer + LW'(1);
        state_n     = (cur_layer_n == layers_lat) ? S_DONE : S_REQ_COEF;
      end
      S_DONE: begin
        state_n     = S_IDLE;
        cur_layer_n = '0;
      end
      S_ERROR:       state_n = S_ERROR;
      default:       state_n = S_IDLE;
    endcase

    // abort overrides every transition out of a non-idle state
    if (abort && state != S_IDLE) begin
      state_n     = S_IDLE;
      cur_layer_n = '0;
    end

    // coef_select is captured on entry to a request and held until the next one
    if (state_n == S_IDLE || state_n == S_REQ_IMAGE) begin
      coef_sel_n = LW'(NUM_LAYERS);
    end else if (state_n == S_REQ_COEF) begin
      coef_sel_n = cur_layer_n;
    end

    wd_en    = (state == S_WAIT_IMAGE) || (state == S_WAIT_COEF) || (state == S_WAIT_LAYER);
    wd_clear = !wd_en;

    request_coef    = (state == S_REQ_IMAGE) || (state == S_REQ_COEF);
    coeff_ready     = (state == S_WAIT_LAYER);
    reset_accum     = (state == S_START_LAYER);
    done_processing = (state == S_DONE);
    error           = (state == S_ERROR);
    busy            = (state != S_IDLE) && (state != S_ERROR);

    if (state == S_LOAD_IMAGE)   load_next = LW'(NUM_LAYERS + 1);
    else if (state == S_ADVANCE) load_next = cur_layer + LW'(1);
    else                         load_next = '0;

    slice_idx = (cur_layer >= LW'(NUM_LAYERS)) ? NUM_LAYERS - 1 : 32'(cur_layer);
    max_input = LAYER_INPUTS[slice_idx*CNT_W +: CNT_W];
  end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed + randomized bench for ann_layer_sequencer against a pass-level timeline model.
module tb_ann_layer_sequencer;

  localparam int LW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start_detecting = 1'b0;
  logic [LW-1:0] layers_used = '0;
  logic          abort = 1'b0;
  logic          image_weights_loaded = 1'b0;
  logic          n_start_done = 1'b0;
  logic [6:0]    max_input;
  logic          coeff_ready, reset_accum, request_coef, busy, done_processing, error;
  logic [LW-1:0] load_next, coef_select, cur_layer;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int unsigned inputs_tab [3] = '{64, 16, 8};

  ann_layer_sequencer #(
    .NUM_LAYERS   (3),
    .CNT_W        (7),
    .LAYER_INPUTS ({7'd8, 7'd16, 7'd64}),
    .TIMEOUT      (TO)
  ) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .start_detecting      (start_detecting),
    .layers_used          (layers_used),
    .abort                (abort),
    .image_weights_loaded (image_weights_loaded),
    .n_start_done         (n_start_done),
    .max_input            (max_input),
    .coeff_ready          (coeff_ready),
    .reset_accum          (reset_accum),
    .load_next            (load_next),
    .request_coef         (request_coef),
    .coef_select          (coef_select),
    .cur_layer            (cur_layer),
    .busy                 (busy),
    .done_processing      (done_processing),
    .error                (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_processing === 1'b1) done_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},    request_coef, 0);
    chk({tag, "_sel"},    coef_select, 3);
    chk({tag, "_layer"},  cur_layer, 0);
    chk({tag, "_load"},   load_next, 0);
    chk({tag, "_maxin"},  max_input, 64);
    chk({tag, "_cready"}, coeff_ready, 0);
    chk({tag, "_racc"},   reset_accum, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done_processing, 0);
    chk({tag, "_err"},    error, 0);
  endtask

  function automatic int eff_layers(input int lu);
    return (lu == 0 || lu > 3) ? 3 : lu;
  endfunction

  // action: 0 none, 1 abort in WAIT_LAYER, 2 timeout in WAIT_LAYER, 3 reset in ADVANCE
  task automatic run_pass(input int lu, input bit fixed, input bit noise,
                          input int stop_at, input int action);
    int nl;
    int d;
    int done0;
    nl = eff_layers(lu);
    done0 = done_seen;
    layers_used = LW'(lu);
    start_detecting = 1'b1;
    tick();
    start_detecting = 1'b0;
    layers_used = LW'($urandom_range(0, 7));
    chk("req_image", request_coef, 1);
    chk("img_select", coef_select, 3);
    chk("busy_run", busy, 1);

    d = fixed ? 2 : int'($urandom_range(1, 12));
    tick();
    if (noise) begin
      #2 n_rst = 1'b0;
      #2 n_rst = 1'b1;
    end
    repeat (d - 1) tick();
    image_weights_loaded = 1'b1;
    tick();
    image_weights_loaded = 1'b0;
    chk("load_image", load_next, 4);
    chk("busy_img", busy, 1);
    tick();

    for (int l = 0; l < nl; l++) begin
      chk("req_coef", request_coef, 1);
      chk("coef_sel", coef_select, l);
      chk("layer_req", cur_layer, l);
      d = fixed ? 2 : int'($urandom_range(1, 12));
      tick();
      if (noise) begin
        n_start_done = 1'b1;
        start_detecting = 1'b1;
      end
      repeat (d - 1) tick();
      image_weights_loaded = 1'b1;
      tick();
      image_weights_loaded = 1'b0;
      n_start_done = 1'b0;
      start_detecting = 1'b0;
      chk("pause_sel", coef_select, l);
      chk("pause_req", request_coef, 0);
      tick();
      chk("reset_accum", reset_accum, 1);
      chk("max_input", max_input, inputs_tab[l]);
      tick();
      chk("coeff_ready", coeff_ready, 1);
      chk("racc_off", reset_accum, 0);

      if (l == stop_at && action == 1) begin
        repeat ($urandom_range(0, 5)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_layer", cur_layer, 0);
        chk("abort_cready", coeff_ready, 0);
        chk("abort_sel", coef_select, 3);
        chk("abort_done", done_seen - done0, 0);
        return;
      end
      if (l == stop_at && action == 2) begin
        repeat (TO - 1) tick();
        chk("wl_pre_err", error, 0);
        chk("wl_pre_cready", coeff_ready, 1);
        tick();
        chk("wl_err", error, 1);
        chk("wl_err_busy", busy, 0);
        chk("wl_err_layer", cur_layer, l);
        n_start_done = 1'b1;
        tick();
        n_start_done = 1'b0;
        chk("wl_err_sticky", error, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wl_err_clear", error, 0);
        chk("wl_abort_layer", cur_layer, 0);
        chk("wl_abort_busy", busy, 0);
        return;
      end

      d = fixed ? 5 : int'($urandom_range(1, 12));
      if (noise) image_weights_loaded = 1'b1;
      repeat (d - 1) tick();
      n_start_done = 1'b1;
      tick();
      n_start_done = 1'b0;
      image_weights_loaded = 1'b0;
      chk("advance_load", load_next, l + 1);
      chk("advance_layer", cur_layer, l);

      if (l == stop_at && action == 3) begin
        n_rst = 1'b0;
        start_detecting = 1'b1;
        abort = 1'b1;
        tick();
        n_rst = 1'b1;
        start_detecting = 1'b0;
        abort = 1'b0;
        chk_reset("rst_adv");
        chk("rst_adv_done", done_seen - done0, 0);
        return;
      end
      tick();
    end

    chk("done_strobe", done_processing, 1);
    chk("done_busy", busy, 1);
    chk("done_layer", cur_layer, nl);
    chk("done_sel", coef_select, nl - 1);
    chk("done_maxin", max_input, inputs_tab[(nl >= 3) ? 2 : nl]);
    tick();
    chk_reset("idle_after");
    chk("done_count", done_seen - done0, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset("rst");
    n_rst = 1'b1;
    tick();
    chk_reset("idle");

    run_pass(3, 1'b1, 1'b0, -1, 0);
    run_pass(1, 1'b1, 1'b0, -1, 0);
    run_pass(0, 1'b1, 1'b0, -1, 0);

    repeat (6) run_pass(int'($urandom_range(0, 7)), 1'b0, 1'(($urandom_range(0, 1))), -1, 0);

    // watchdog in WAIT_IMAGE
    layers_used = 3'd3;
    start_detecting = 1'b1;
    tick();
    start_detecting = 1'b0;
    repeat (TO) tick();
    chk("wi_pre_err", error, 0);
    chk("wi_pre_busy", busy, 1);
    tick();
    chk("wi_err", error, 1);
    chk("wi_err_busy", busy, 0);
    chk("wi_err_layer", cur_layer, 0);
    image_weights_loaded = 1'b1;
    repeat (3) tick();
    image_weights_loaded = 1'b0;
    chk("wi_err_sticky", error, 1);
    abort = 1'b1;
    tick();
    chk_reset("wi_abort");
    start_detecting = 1'b1;
    tick();
    start_detecting = 1'b0;
    chk("idle_abort_start", request_coef, 1);
    tick();
    abort = 1'b0;
    chk_reset("abort_req");

    run_pass(3, 1'b0, 1'b0, 1, 2);
    run_pass(3, 1'b0, 1'b0, 1, 1);
    run_pass(2, 1'b0, 1'b0, -1, 0);
    run_pass(3, 1'b0, 1'b0, 1, 3);
    run_pass(int'($urandom_range(0, 7)), 1'b0, 1'b0, -1, 0);
    run_pass(3, 1'b1, 1'b1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
